// File: rtl/ex_execute_unit.sv
// rtl/ex_execute_unit.sv - EX stage: ALU, branch resolve, single-cycle multiply, iterative divide
module ex_execute_unit #(
   parameter int XLEN            = 64,
   parameter int ALU_OP_WIDTH    = 7,
   parameter int ALU_FUNC3_WIDTH = 3,
   parameter int ALU_FUNC7_WIDTH = 7
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       valid_in,
   input  logic                       reg_to_pc,
   input  logic                       alu_src,
   input  logic [ALU_OP_WIDTH-1:0]    alu_op,
   input  logic [ALU_FUNC3_WIDTH-1:0] alu_func3,
   input  logic [ALU_FUNC7_WIDTH-1:0] alu_func7,
   input  logic [XLEN-1:0]            pc,
   input  logic [XLEN-1:0]            rs1_val,
   input  logic [XLEN-1:0]            rs2_val,
   input  logic [XLEN-1:0]            imm,
   output logic                       stall_out,
   output logic                       out_valid,
   output logic [XLEN-1:0]            out_result,
   output logic [XLEN-1:0]            out_store_data,
   output logic                       out_branch_taken,
   output logic [XLEN-1:0]            out_target
);

   localparam int SHW = $clog2(XLEN);
   localparam int CW  = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [ALU_OP_WIDTH-1:0] OPC_OP     = 7'b0110011;
   localparam logic [ALU_OP_WIDTH-1:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [ALU_OP_WIDTH-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [ALU_OP_WIDTH-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [ALU_OP_WIDTH-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [ALU_OP_WIDTH-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [ALU_OP_WIDTH-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [ALU_OP_WIDTH-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [ALU_OP_WIDTH-1:0] OPC_STORE  = 7'b0100011;

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
   logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d, want_rem_q, want_rem_d;
   logic            out_valid_q, out_valid_d, out_branch_taken_q, out_branch_taken_d;
   logic [XLEN-1:0] out_result_q, out_result_d, out_store_data_q, out_store_data_d;
   logic [XLEN-1:0] out_target_q, out_target_d;

   logic [XLEN-1:0] op_a, op_b, a_mag, b_mag, sra_res;
   logic [SHW-1:0]  shamt;
   logic            is_op, is_m, is_div, div_signed, div_zero, div_ovf, div_long;
   logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
   logic [XLEN:0]   rem_sh, rem_sub;
   logic            alu_ok, alu_taken;
   logic [XLEN-1:0] alu_res, alu_target;

   assign op_a  = reg_to_pc ? pc : rs1_val;
   assign op_b  = alu_src ? imm : rs2_val;
   assign shamt = op_b[SHW-1:0];
   assign sra_res = $signed(op_a) >>> shamt;

   assign is_op      = (alu_op == OPC_OP);
   assign is_m       = is_op && (alu_func7 == ALU_FUNC7_WIDTH'(1));
   assign is_div     = is_m && alu_func3[2];
   assign div_signed = !alu_func3[0];
   assign div_zero   = (op_b == '0);
   assign div_ovf    = div_signed && (op_a == MOST_NEG) && (op_b == '1);
   assign div_long   = is_div && !div_zero && !div_ovf;

   // Divider works on magnitudes; signs are reapplied when the result is written
   assign a_mag = (div_signed && op_a[XLEN-1]) ? -op_a : op_a;
   assign b_mag = (div_signed && op_b[XLEN-1]) ? -op_b : op_b;

   // MULH/MULHSU sign-extend A, only MULH sign-extends B; the upper half is then exact
   assign mul_a = {{XLEN{((alu_func3 == 3'd1) || (alu_func3 == 3'd2)) && op_a[XLEN-1]}}, op_a};
   assign mul_b = {{XLEN{(alu_func3 == 3'd1) && op_b[XLEN-1]}}, op_b};
   assign mul_p = mul_a * mul_b;

   // One restoring step: shift in the next dividend bit, keep the subtraction if it did not borrow
   assign rem_sh  = {rem_q, quo_q[XLEN-1]};
   assign rem_sub = rem_sh - {1'b0, dvsr_q};

   assign stall_out = !reset && !flush &&
                      (((state_q == IDLE) && valid_in && div_long) || (state_q == DIV));

   // Single-cycle result for every op except a divide that needs the iterative path
   always_comb begin
      alu_ok     = 1'b1;
      alu_res    = '0;
      alu_taken  = 1'b0;
      alu_target = '0;
      case (alu_op)
         OPC_OP, OPC_OPIMM: begin
            if (is_m) begin
               if (!alu_func3[2])
                  alu_res = (alu_func3 == 3'd0) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
               else if (div_zero)
                  alu_res = alu_func3[1] ? op_a : '1;
               else
                  alu_res = alu_func3[1] ? '0 : op_a;
            end else begin
               case (alu_func3)
                  3'd0: alu_res = (is_op && alu_func7[5]) ? op_a - op_b : op_a + op_b;
                  3'd1: alu_res = op_a << shamt;
                  3'd2: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                  3'd3: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
                  3'd4: alu_res = op_a ^ op_b;
                  3'd5: alu_res = alu_func7[5] ? sra_res : op_a >> shamt;
                  3'd6: alu_res = op_a | op_b;
                  default: alu_res = op_a & op_b;
               endcase
            end
         end
         OPC_LUI:   alu_res = imm;
         OPC_AUIPC: alu_res = pc + imm;
         OPC_JAL: begin
            alu_res    = pc + XLEN'(4);
            alu_target = pc + imm;
            alu_taken  = 1'b1;
         end
         OPC_JALR: begin
            alu_res    = pc + XLEN'(4);
            alu_target = (rs1_val + imm) & ~XLEN'(1);
            alu_taken  = 1'b1;
         end
         OPC_BRANCH: begin
            alu_target = pc + imm;
            case (alu_func3)
               3'd0:    alu_taken = (rs1_val == rs2_val);
               3'd1:    alu_taken = (rs1_val != rs2_val);
               3'd4:    alu_taken = ($signed(rs1_val) < $signed(rs2_val));
               3'd5:    alu_taken = ($signed(rs1_val) >= $signed(rs2_val));
               3'd6:    alu_taken = (rs1_val < rs2_val);
               3'd7:    alu_taken = (rs1_val >= rs2_val);
               default: alu_taken = 1'b0;
            endcase
         end
         OPC_LOAD, OPC_STORE: alu_res = rs1_val + imm;
         default: alu_ok = 1'b0;
      endcase
   end

   // Divide sequencing and EX/MEM register next values; flush overrides everything
   always_comb begin
      state_d            = state_q;
      cnt_d              = cnt_q;
      rem_d              = rem_q;
      quo_d              = quo_q;
      dvsr_d             = dvsr_q;
      q_neg_d            = q_neg_q;
      r_neg_d            = r_neg_q;
      want_rem_d         = want_rem_q;
      out_valid_d        = out_valid_q;
      out_result_d       = out_result_q;
      out_store_data_d   = out_store_data_q;
      out_branch_taken_d = out_branch_taken_q;
      out_target_d       = out_target_q;
      if (flush) begin
         state_d            = IDLE;
         cnt_d              = '0;
         out_valid_d        = 1'b0;
         out_branch_taken_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_in && div_long) begin
                  state_d            = DIV;
                  cnt_d              = CW'(XLEN);
                  rem_d              = '0;
                  quo_d              = a_mag;
                  dvsr_d             = b_mag;
                  q_neg_d            = div_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                  r_neg_d            = div_signed && op_a[XLEN-1];
                  want_rem_d         = alu_func3[1];
                  out_valid_d        = 1'b0;
                  out_branch_taken_d = 1'b0;
                  out_store_data_d   = rs2_val;
               end else if (valid_in && alu_ok) begin
                  out_valid_d        = 1'b1;
                  out_result_d       = alu_res;
                  out_store_data_d   = rs2_val;
                  out_branch_taken_d = alu_taken;
                  out_target_d       = alu_target;
               end else begin
                  out_valid_d        = 1'b0;
                  out_branch_taken_d = 1'b0;
               end
            end
            DIV: begin
               out_valid_d        = 1'b0;
               out_branch_taken_d = 1'b0;
               cnt_d              = cnt_q - CW'(1);
               if (!rem_sub[XLEN]) begin
                  rem_d = rem_sub[XLEN-1:0];
                  quo_d = {quo_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_d = rem_sh[XLEN-1:0];
                  quo_d = {quo_q[XLEN-2:0], 1'b0};
               end
               if (cnt_q == CW'(1))
                  state_d = DONE;
            end
            DONE: begin
               state_d            = IDLE;
               out_valid_d        = 1'b1;
               out_branch_taken_d = 1'b0;
               out_result_d       = want_rem_q ? (r_neg_q ? -rem_q : rem_q)
                                               : (q_neg_q ? -quo_q : quo_q);
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and EX/MEM register, synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q            <= IDLE;
         cnt_q              <= '0;
         rem_q              <= '0;
         quo_q              <= '0;
         dvsr_q             <= '0;
         q_neg_q            <= 1'b0;
         r_neg_q            <= 1'b0;
         want_rem_q         <= 1'b0;
         out_valid_q        <= 1'b0;
         out_result_q       <= '0;
         out_store_data_q   <= '0;
         out_branch_taken_q <= 1'b0;
         out_target_q       <= '0;
      end else begin
         state_q            <= state_d;
         cnt_q              <= cnt_d;
         rem_q              <= rem_d;
         quo_q              <= quo_d;
         dvsr_q             <= dvsr_d;
         q_neg_q            <= q_neg_d;
         r_neg_q            <= r_neg_d;
         want_rem_q         <= want_rem_d;
         out_valid_q        <= out_valid_d;
         out_result_q       <= out_result_d;
         out_store_data_q   <= out_store_data_d;
         out_branch_taken_q <= out_branch_taken_d;
         out_target_q       <= out_target_d;
      end
   end

   assign out_valid        = out_valid_q;
   assign out_result       = out_result_q;
   assign out_store_data   = out_store_data_q;
   assign out_branch_taken = out_branch_taken_q;
   assign out_target       = out_target_q;

endmodule
